data_mem: RTL and testbench
===========================

# data_mem

Data memory responder at the far end of the load/store command interface. It consumes the `mem_en`/`mem_wr`/`mem_addr`/`mem_wdata` command produced in the memory stage and holds it off with `mem_busy` for a configurable number of wait states. It then performs the word access and returns read data with a one-cycle completion strobe. It sits between the memory stage and the pipeline stall logic, and emulates a slow on-chip data RAM.

## Interface

- `ADDR_W`, default 10: word-address width; storage is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states per access; legal range 0..15.

Ports:

- `clk` in 1: the only clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_en` in 1: command valid; held stable by the pipeline while `mem_busy` is high.
- `mem_wr` in 1: 1 = store, 0 = load; ignored when `mem_en` is 0.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: load data, registered.
- `mem_rvalid` out 1: one-cycle strobe when a load completes.
- `mem_done` out 1: one-cycle strobe when any access completes.
- `mem_err` out 1: one-cycle strobe with `mem_done` when the access was misaligned.
- `mem_busy` out 1: stall request to the pipeline.

## Operation

- FSM states are IDLE, WAIT and DONE.
- **IDLE.**
  - On an edge with `mem_en`=1, latch addr, wdata and wr.
  - If `WAIT_CYCLES`=0: perform the access at this edge, then go to DONE.
  - Otherwise load `cnt` = `WAIT_CYCLES`-1 and go to WAIT.
- **WAIT.**
  - While `cnt`≠0, decrement `cnt`.
  - When `cnt`=0, perform the access at this edge, then go to DONE.
- **DONE.** Lasts exactly one cycle, then goes to IDLE unconditionally. `mem_en` is ignored in DONE, because the pipeline still presents the completed command in that cycle.
- **Access.**
  - Index = latched addr[ADDR_W+1:2]; addr[31:ADDR_W+2] are ignored, so the address space aliases (wraps) modulo 2^(ADDR_W+2).
  - Store: writes word[index] ← wdata.
  - Load: `mem_rdata` ← word[index].
  - Misaligned (addr[1:0]≠0): no write; on a load, `mem_rdata` ← 0; `mem_err`=1 in DONE.
- **Outputs in DONE.**
  - `mem_done`=1.
  - `mem_rvalid`=1 only for loads, including misaligned loads.
  - `mem_err` as above.
  - All three are 0 in every other state.
- `mem_rdata` holds its value until the next load completes; stores do not change it.
- `mem_busy` = (IDLE & `mem_en`) | WAIT. It is combinational, 0 in DONE and 0 while `rst` is high.
- Storage array is not reset; its contents are undefined until written.

## Timing

- Command presented in cycle T while in IDLE; WAIT occupies T+1..T+WAIT_CYCLES.
- Access edge is the end of cycle T+WAIT_CYCLES; DONE is cycle T+WAIT_CYCLES+1.
- Total occupancy is WAIT_CYCLES+2 cycles per access. `mem_busy` is high for WAIT_CYCLES+1 cycles, from T to T+WAIT_CYCLES.
- With `WAIT_CYCLES`=0: busy only in T, DONE in T+1.
- Back-to-back: a new command can be accepted at the earliest in the cycle after DONE.
- A store at the end of cycle X is visible to any load whose access edge is later than X; no forwarding is required.
- Reset, asynchronous and at any time:
  - State ← IDLE, `cnt` ← 0.
  - `mem_rdata` ← 0; `mem_rvalid`, `mem_done`, `mem_err` ← 0.
  - A pending store whose access edge has not occurred is discarded.
  - Storage is not modified.
- Inputs are sampled only at acceptance in IDLE; later changes while busy do not affect the access.

## Test plan

- **Reset values.** Assert `rst` mid-cycle -> all outputs 0 immediately; with `mem_en`=1 held, `mem_busy` stays 0 until `rst` falls.
- **Store then load, `WAIT_CYCLES`=2.**
  - Store 0xDEADBEEF to 0x0000_0010 -> `mem_busy` high for 3 cycles, `mem_done` 1 cycle, `mem_rvalid`=0.
  - Then load 0x10 -> `mem_rdata`=0xDEADBEEF with `mem_rvalid` in cycle T+3.
- **Misaligned store.** Store 0x12345678 to 0x13 -> `mem_err`=1 in DONE; a subsequent load of 0x10 still returns 0xDEADBEEF.
- **Aliasing.** With `ADDR_W`=10, store 0xA5A5A5A5 to 0x0000_1004, then load 0x0000_0004 -> 0xA5A5A5A5.
- **`WAIT_CYCLES`=0 back-to-back.** Store 1 to 0x0, store 2 to 0x4, load 0x0, load 0x4 -> each access takes 2 cycles; loads return 1 and 2.
- **Reset mid-access.** Assert `rst` while in WAIT during a store of 0xFFFFFFFF to 0x8 that overwrites 0x55 -> after reset, a load of 0x8 returns 0x55.

Source files
------------

// File: rtl/data_mem.sv
// rtl/data_mem.sv - wait-stated word data memory responder for load/store commands
//
// Ports:
//   clk         clock; all state changes on its rising edge
//   rst         asynchronous active-high reset; storage contents are kept
//   mem_en      command valid, held by the pipeline while mem_busy is high
//   mem_wr      1 = store, 0 = load
//   mem_addr    byte address; only bits [ADDR_W+1:0] are used, so the space aliases
//   mem_wdata   store data
//   mem_rdata   registered load data, holds until the next load completes
//   mem_rvalid  one-cycle strobe when a load completes
//   mem_done    one-cycle strobe when any access completes
//   mem_err     one-cycle strobe with mem_done when the access was misaligned
//   mem_busy    combinational stall request to the pipeline
module data_mem #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_wr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        mem_done,
   output logic        mem_err,
   output logic        mem_busy
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic [ADDR_W+1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              lat_wr;

   logic [31:0]       ram [DEPTH];

   logic              accept;
   logic              access;
   logic [ADDR_W+1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic              acc_wr;
   logic              acc_aligned;
   logic [ADDR_W-1:0] acc_idx;
   logic              ram_we;

   // Upper address bits are deliberately dropped; the memory wraps.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

   assign accept = (state == ST_IDLE) && mem_en;

   always_comb begin
      state_nxt = state;
      access    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_en) begin
               if (WAIT_CYCLES == 0) begin
                  access    = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accepting edge, before
   // the command has been latched, so the live inputs are used there.
   always_comb begin
      if (state == ST_IDLE) begin
         acc_addr  = mem_addr[ADDR_W+1:0];
         acc_wdata = mem_wdata;
         acc_wr    = mem_wr;
      end else begin
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
         acc_wr    = lat_wr;
      end
   end

   assign acc_aligned = (acc_addr[1:0] == 2'b00);
   assign acc_idx     = acc_addr[ADDR_W+1:2];

   // Gating with rst keeps a store from landing on an edge where reset is held.
   assign ram_we = access && acc_wr && acc_aligned && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            lat_addr  <= mem_addr[ADDR_W+1:0];
            lat_wdata <= mem_wdata;
            lat_wr    <= mem_wr;
            cnt       <= CNT_LOAD;
         end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (access && !acc_wr) begin
            mem_rdata <= acc_aligned ? ram[acc_idx] : 32'd0;
         end
      end
   end

   // Storage has no reset so it can map onto a plain RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[acc_idx] <= acc_wdata;
      end
   end

   assign mem_done   = (state == ST_DONE);
   assign mem_rvalid = mem_done && !lat_wr;
   assign mem_err    = mem_done && (lat_addr[1:0] != 2'b00);
   assign mem_busy   = !rst && (accept || (state == ST_WAIT));

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem, two instances (2 and 0 wait states)
module tb_data_mem;

   localparam int AW = 10;
   localparam int W0 = 2;
   localparam int W1 = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  en, wr, rvalid, done, err, busy;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];

   always #5 clk = ~clk;

   data_mem #(.ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut0 (
      .clk(clk), .rst(rst), .mem_en(en[0]), .mem_wr(wr[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_rvalid(rvalid[0]),
      .mem_done(done[0]), .mem_err(err[0]), .mem_busy(busy[0])
   );

   data_mem #(.ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_en(en[1]), .mem_wr(wr[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_rvalid(rvalid[1]),
      .mem_done(done[1]), .mem_err(err[1]), .mem_busy(busy[1])
   );

   typedef struct {
      logic        rv;
      logic        er;
      logic [31:0] rd;
      bit          known;
      int          cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] m0 [int];
   logic [31:0] m1 [int];
   logic [31:0] last_rd  [2];
   bit          rd_known [2];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last_rd[k]  = 32'd0;
         rd_known[k] = 1'b1;
      end
   endtask

   // Reference: word index is the byte address divided by four, wrapped to the depth.
   task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   idx;
      int   wc;
      int   nb;
      bit   al;
      wc  = (k == 0) ? W0 : W1;
      idx = int'((a / 4) % (1 << AW));
      al  = (a % 4) == 0;
      if (w) begin
         if (al) begin
            if (k == 0) m0[idx] = d;
            else        m1[idx] = d;
         end
      end else if (!al) begin
         last_rd[k]  = 32'd0;
         rd_known[k] = 1'b1;
      end else if ((k == 0) ? m0.exists(idx) : m1.exists(idx)) begin
         last_rd[k]  = (k == 0) ? m0[idx] : m1[idx];
         rd_known[k] = 1'b1;
      end else begin
         rd_known[k] = 1'b0;
      end
      e.rv    = !w;
      e.er    = !al;
      e.rd    = last_rd[k];
      e.known = rd_known[k];

      @(posedge clk); #1;
      en[k]    = 1'b1;
      wr[k]    = w;
      addr[k]  = a;
      wdata[k] = d;
      e.cyc    = cyc + wc + 1;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);

      // Inputs are scrambled after acceptance; only the accepted command may matter.
      nb = 0;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (!busy[k]) break;
         nb++;
         @(posedge clk); #1;
         wr[k]    = 1'($urandom);
         addr[k]  = $urandom;
         wdata[k] = $urandom;
      end
      check($sformatf("busy_len%0d", k), nb, wc + 1);
   endtask

   task automatic idle(input int k);
      @(posedge clk); #1;
      en[k] = 1'b0;
   endtask

   task automatic rand_op(input int k);
      logic [31:0] a;
      a = ($urandom % 16) * 4;
      if (($urandom % 4) == 0) a = a + 32'h1000 * ($urandom % 8);
      if (($urandom % 8) == 0) a = a + 1 + ($urandom % 3);
      issue(k, 1'($urandom), a, $urandom);
      if (($urandom % 3) == 0) idle(k);
   endtask

   task automatic mon(input int k);
      exp_t e;
      if (done[k]) begin
         if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done%0d: got done with no access outstanding", k);
         end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("done_cycle%0d", k), cyc, e.cyc);
            check($sformatf("rvalid%0d", k), rvalid[k], e.rv);
            check($sformatf("err%0d", k), err[k], e.er);
            if (e.known) check($sformatf("rdata%0d", k), rdata[k], e.rd);
         end
      end else begin
         check($sformatf("rvalid_idle%0d", k), rvalid[k], 1'b0);
         check($sformatf("err_idle%0d", k), err[k], 1'b0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 2'b11;
      wr  = 2'b00;
      for (int k = 0; k < 2; k++) begin
         addr[k]  = 32'h0;
         wdata[k] = 32'h0;
      end
      model_reset();
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check("rst_busy", busy[k], 1'b0);
            check("rst_done", done[k], 1'b0);
            check("rst_rdata", rdata[k], 32'd0);
         end
      end
      @(posedge clk); #1;
      en = 2'b00;
      #2 rst = 1'b0;

      // Two wait states: directed sequence.
      issue(0, 1, 32'h0000_0010, 32'hDEAD_BEEF); idle(0);
      issue(0, 0, 32'h0000_0010, 32'h0);         idle(0);
      issue(0, 1, 32'h0000_0013, 32'h1234_5678); idle(0);
      issue(0, 0, 32'h0000_0010, 32'h0);         idle(0);
      issue(0, 1, 32'h0000_1004, 32'hA5A5_A5A5); idle(0);
      issue(0, 0, 32'h0000_0004, 32'h0);         idle(0);
      issue(0, 0, 32'h0000_0011, 32'h0);         idle(0);
      issue(0, 1, 32'h0000_0008, 32'h0000_0055);
      issue(0, 0, 32'h0000_0008, 32'h0);         idle(0);

      // Reset while a store to 0x8 sits in WAIT; it must be discarded.
      @(posedge clk); #1;
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("midrst_busy", busy[0], 1'b0);
      check("midrst_done", done[0], 1'b0);
      check("midrst_rvalid", rvalid[0], 1'b0);
      check("midrst_rdata", rdata[0], 32'd0);
      @(posedge clk); @(posedge clk); #1;
      check("midrst_busy_hold", busy[0], 1'b0);
      en[0] = 1'b0;
      #2 rst = 1'b0;
      issue(0, 0, 32'h0000_0008, 32'h0); idle(0);
      issue(0, 0, 32'h0000_0010, 32'h0); idle(0);

      for (int i = 0; i < 60; i++) rand_op(0);
      idle(0);

      // Zero wait states: back-to-back accesses.
      issue(1, 1, 32'h0, 32'd1);
      issue(1, 1, 32'h4, 32'd2);
      issue(1, 0, 32'h0, 32'h0);
      issue(1, 0, 32'h4, 32'h0);
      issue(1, 0, 32'h6, 32'h0);
      idle(1);
      for (int i = 0; i < 60; i++) rand_op(1);
      idle(1);

      repeat (5) @(posedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
